pwm_capture: RTL
================

# pwm_capture

Input-capture block that sits directly downstream of the PWM generator. It samples the generator's `cio_pwm_o` (or an external pin) on `pwm_i` and measures high time and period in `clk_i` cycles. Results are exposed on the same valid/ready register bus the generator uses, and `irq_o` flags each completed measurement. It serves as the on-chip loopback checker for the generator and as a general-purpose duty/period meter.

## Interface

**Parameters**
- `BITS`, default 32: bus data/address width and counter width.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `pwm_i`, minimum 2.

**Ports**
- `clk_i`, input, 1: single clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `valid_i`, input, 1: bus request.
- `we_i`, input, 1: 1 = write, 0 = read.
- `addr_i`, input, `BITS`: byte address; word index is `addr_i[7:2]`.
- `wdata_i`, input, `BITS`: write data.
- `ready_o`, output, 1: one-cycle acknowledge.
- `rdata_o`, output, `BITS`: registered read data.
- `pwm_i`, input, 1: signal under measurement, asynchronous to `clk_i`.
- `irq_o`, output, 1: one-cycle pulse per completed measurement.

## Operation

**Register map (word index)**
- 0 CTRL (RW)
  - bit0 `enable`.
  - bit1 `irq_en`.
  - bit2 `clear`: write-1, self-clearing, always reads 0.
- 1 STATUS (RO)
  - bit0 `valid`: sticky.
  - bit1 `overflow`: sticky.
  - bit2: current synchronized level.
- 2 HIGH_TIME (RO).
- 3 PERIOD (RO).
- 4 EDGE_COUNT (RO): completed periods, wraps at 2^BITS.
- 5 TIMEOUT (RW): 0 disables the timeout.
- Writes to RO or unmapped words are ignored. Reads of unmapped words return 0.

**Bus**
- A request is accepted when `valid_i && !ready_o`.
- `ready_o` goes to 1 the next cycle for exactly one cycle.
- On a read, `rdata_o` is loaded in the same cycle `ready_o` rises and holds its value until the next read.

**Input path**
- `pwm_i` passes through `SYNC_STAGES` flops, then one delay flop.
- rise = sync & ~prev; fall = ~sync & prev.

**FSM**
- DISABLED
  - `cnt` = 0.
  - Moves to WAIT_RISE when `enable` = 1.
- WAIT_RISE
  - On rise: `cnt` <= 1, go to MEAS_HIGH.
- MEAS_HIGH
  - `cnt` increments each cycle.
  - On fall: `hi_lat` <= `cnt`, go to MEAS_LOW.
- MEAS_LOW
  - `cnt` increments each cycle.
  - On rise:
    - HIGH_TIME <= `hi_lat`, PERIOD <= `cnt`.
    - `valid` <= 1, EDGE_COUNT += 1.
    - `irq_o` pulses next cycle if `irq_en`.
    - `cnt` <= 1, stay measuring: go to MEAS_HIGH.
- Any state with `enable` = 0: go to DISABLED next cycle. HIGH_TIME, PERIOD, STATUS and EDGE_COUNT are retained.
- Timeout/saturation, in MEAS_HIGH or MEAS_LOW:
  - Triggers if `TIMEOUT` != 0 and `cnt` == `TIMEOUT`, or if `cnt` reaches all-ones.
  - Action: `overflow` <= 1, discard the partial measurement, go to WAIT_RISE.
- Count semantics: HIGH_TIME and PERIOD are the number of `clk_i` cycles the synchronized signal spent high, and high+low, respectively.

**Simultaneous events**
- Capture and `clear` in the same cycle: `clear` wins for `valid`, `overflow` and EDGE_COUNT. HIGH_TIME and PERIOD still take the new values.
- Bus read and capture in the same cycle: the read returns the pre-capture value.
- Writing CTRL with `enable` = 0 mid-measurement: the FSM aborts, no `overflow` is set, and no capture occurs.

## Timing

**Reset values:** all of the following are 0.
- `ready_o`, `rdata_o`, `irq_o`.
- All registers, synchronizer flops, `cnt` and `hi_lat`.
- FSM = DISABLED.

**Latencies**
- `pwm_i` edge to edge detect: `SYNC_STAGES` + 1 cycles.
- Completing rise detect to PERIOD readable: 1 cycle.
- Completing rise detect to `irq_o`: 1 cycle.
- Bus: request to `ready_o` = 1 cycle. Back-to-back requests sustain one access every 2 cycles.

**Other rules**
- Reset asserted mid-operation returns every state element to its reset value immediately and asynchronously.
- Pulses on `pwm_i` shorter than 1 cycle after synchronization may be missed. This is by design.

## Structure

**Shared package `pwm_pkg`**
- Register word indices for CTRL, STATUS, HIGH_TIME, PERIOD, EDGE_COUNT and TIMEOUT.
- CTRL and STATUS bit positions.
- 2-bit FSM state encoding: DISABLED=0, WAIT_RISE=1, MEAS_HIGH=2, MEAS_LOW=3.
- The generator's mode encodings also move here.

**Sub-module `pwm_capture_sync`**
- Contains the synchronizer chain plus edge detector.
- Parameter `SYNC_STAGES`.
- Outputs `level_o`, `rise_o`, `fall_o`.

**Top level:** FSM, counters and bus register file.

## Test plan

1. **Reset:** `rst_ni`=0 asserted mid-cycle → all outputs 0 immediately; every register reads 0 after release.
2. **Basic capture:** write CTRL=3; drive `pwm_i` synchronously with high=3 and period=10 for 4 periods → HIGH_TIME=3, PERIOD=10, EDGE_COUNT=3, STATUS.valid=1, exactly 3 `irq_o` pulses.
3. **Timeout:** write TIMEOUT=20; drive `pwm_i` high for 50 cycles → STATUS.overflow=1, no capture, EDGE_COUNT unchanged, FSM returns to WAIT_RISE.
4. **Clear during capture:** write CTRL.clear in the same cycle as a completing rise → `valid`=0, EDGE_COUNT=0, PERIOD holds the new value.
5. **Disable mid-measure:** write CTRL=0 during MEAS_LOW → no capture, no `irq_o`, previous HIGH_TIME/PERIOD retained. Re-enabling → first capture only after a full period.
6. **Bus protocol:** hold `valid_i` high continuously → `ready_o` toggles 0/1. A read of index 7 returns 0. A write to PERIOD leaves its value unchanged.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//   Contents: register word indices, CTRL/STATUS bit positions,
//   capture FSM state encoding, generator mode encodings.
package pwm_pkg;

  // Register word indices (addr[7:2])
  localparam logic [5:0] IDX_CTRL       = 6'd0;
  localparam logic [5:0] IDX_STATUS     = 6'd1;
  localparam logic [5:0] IDX_HIGH_TIME  = 6'd2;
  localparam logic [5:0] IDX_PERIOD     = 6'd3;
  localparam logic [5:0] IDX_EDGE_COUNT = 6'd4;
  localparam logic [5:0] IDX_TIMEOUT    = 6'd5;

  // CTRL bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  // STATUS bit positions
  localparam int STAT_VALID    = 0;
  localparam int STAT_OVERFLOW = 1;
  localparam int STAT_LEVEL    = 2;

  // Capture FSM states
  typedef enum logic [1:0] {
    ST_DISABLED  = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEAS_HIGH = 2'd2,
    ST_MEAS_LOW  = 2'd3
  } cap_state_e;

  // Generator output modes
  typedef enum logic [1:0] {
    PWM_MODE_STANDARD  = 2'd0,
    PWM_MODE_BLINK     = 2'd1,
    PWM_MODE_HEARTBEAT = 2'd2
  } pwm_mode_e;

endpackage

// File: rtl/pwm_capture_sync.sv
// Synchronizer chain plus edge detector for the asynchronous capture input.
// Latency: pwm_i edge to rise_o/fall_o = SYNC_STAGES cycles (consumed one edge later).
// Backpressure: none; free-running every cycle.
//   Ports: clk_i, rst_ni (async active-low), pwm_i (async input),
//          level_o (synchronized level), rise_o / fall_o (one-cycle edge strobes).
module pwm_capture_sync
  import pwm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pwm_i};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level_o = chain[SYNC_STAGES-1];
  assign rise_o  =  level_o & ~prev;
  assign fall_o  = ~level_o &  prev;

endmodule

// File: rtl/pwm_capture.sv
// Input-capture block: measures high time and period of pwm_i in clk_i cycles.
// Latency: completing rise detect -> PERIOD/irq_o 1 cycle; bus request -> ready_o 1 cycle.
// Backpressure: one access accepted every 2 cycles (valid_i && !ready_o); no stalls otherwise.
//   Ports: clk_i, rst_ni (async active-low); valid_i/we_i/addr_i/wdata_i bus request,
//          ready_o one-cycle acknowledge, rdata_o registered read data;
//          pwm_i measured signal (async), irq_o one pulse per completed measurement.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned BITS        = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic            we_i,
  input  logic [BITS-1:0] addr_i,
  input  logic [BITS-1:0] wdata_i,
  output logic            ready_o,
  output logic [BITS-1:0] rdata_o,
  input  logic            pwm_i,
  output logic            irq_o
);

  localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

  // Input path
  logic level, rise, fall;

  pwm_capture_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .pwm_i  (pwm_i),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Register state
  logic            enable, irq_en;
  logic            valid, overflow;
  logic [BITS-1:0] timeout_lim;
  logic [BITS-1:0] high_time, period, edge_count;

  // FSM state
  cap_state_e      state, state_nxt;
  logic [BITS-1:0] cnt, cnt_nxt;
  logic [BITS-1:0] hi_lat, hi_lat_nxt;
  logic            capture, timeout_hit, limit;

  // Bus decode
  logic [5:0] idx;
  logic       accept, wr, rd, wr_ctrl, clear, enable_eff;
  logic       unused_addr;

  assign idx         = addr_i[7:2];
  assign unused_addr = ^{addr_i[BITS-1:8], addr_i[1:0]};
  assign accept      = valid_i & ~ready_o;
  assign wr          = accept &  we_i;
  assign rd          = accept & ~we_i;
  assign wr_ctrl     = wr && (idx == IDX_CTRL);
  assign clear       = wr_ctrl & wdata_i[CTRL_CLEAR];

  // A CTRL write takes effect on the FSM in the same cycle it is accepted, so
  // clearing enable can never race a completing rise into a capture.
  assign enable_eff  = wr_ctrl ? wdata_i[CTRL_ENABLE] : enable;

  // Abort the measurement on a user timeout or when the counter would wrap.
  assign limit = ((timeout_lim != '0) && (cnt == timeout_lim)) || (cnt == '1);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_lat_nxt  = hi_lat;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    if (!enable_eff) begin
      state_nxt = ST_DISABLED;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_DISABLED: begin
          state_nxt = ST_WAIT_RISE;
          cnt_nxt   = '0;
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            cnt_nxt   = ONE;
            state_nxt = ST_MEAS_HIGH;
          end
        end
        ST_MEAS_HIGH: begin
          if (limit) begin
            timeout_hit = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = ST_WAIT_RISE;
          end else begin
            // The falling-edge cycle itself is the first low cycle, so cnt
            // keeps counting through it and PERIOD comes out as high+low.
            cnt_nxt = cnt + ONE;
            if (fall) begin
              hi_lat_nxt = cnt;
              state_nxt  = ST_MEAS_LOW;
            end
          end
        end
        ST_MEAS_LOW: begin
          if (limit) begin
            timeout_hit = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = ST_WAIT_RISE;
          end else if (rise) begin
            capture   = 1'b1;
            cnt_nxt   = ONE;
            state_nxt = ST_MEAS_HIGH;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        default: begin
          state_nxt = ST_DISABLED;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_DISABLED;
      cnt    <= '0;
      hi_lat <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hi_lat <= hi_lat_nxt;
    end
  end

  // Results and sticky status. clear beats a same-cycle capture/timeout for
  // the status bits and EDGE_COUNT, while HIGH_TIME/PERIOD still update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      high_time  <= '0;
      period     <= '0;
      edge_count <= '0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      if (capture) begin
        high_time <= hi_lat;
        period    <= cnt;
      end
      if (clear) begin
        valid      <= 1'b0;
        overflow   <= 1'b0;
        edge_count <= '0;
      end else begin
        if (capture) begin
          valid      <= 1'b1;
          edge_count <= edge_count + ONE;
        end
        if (timeout_hit) begin
          overflow <= 1'b1;
        end
      end
      irq_o <= capture & irq_en;
    end
  end

  // Writable registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      timeout_lim <= '0;
    end else if (wr) begin
      if (idx == IDX_CTRL) begin
        enable <= wdata_i[CTRL_ENABLE];
        irq_en <= wdata_i[CTRL_IRQ_EN];
      end
      if (idx == IDX_TIMEOUT) begin
        timeout_lim <= wdata_i;
      end
    end
  end

  // Read mux; sampled at the accept edge, so a same-cycle capture is not visible.
  logic [BITS-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (idx)
      IDX_CTRL: begin
        rd_val[CTRL_ENABLE] = enable;
        rd_val[CTRL_IRQ_EN] = irq_en;
      end
      IDX_STATUS: begin
        rd_val[STAT_VALID]    = valid;
        rd_val[STAT_OVERFLOW] = overflow;
        rd_val[STAT_LEVEL]    = level;
      end
      IDX_HIGH_TIME:  rd_val = high_time;
      IDX_PERIOD:     rd_val = period;
      IDX_EDGE_COUNT: rd_val = edge_count;
      IDX_TIMEOUT:    rd_val = timeout_lim;
      default:        rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_o <= 1'b0;
      rdata_o <= '0;
    end else begin
      ready_o <= accept;
      if (rd) begin
        rdata_o <= rd_val;
      end
    end
  end

endmodule
